mem_target: RTL and testbench
=============================

MEM_TARGET -- requirements
Module: mem_target

Interface
REQ-001 Parameter WAIT_STATES, default 1, meaning: extra wait cycles inserted before ack; legal range 0..3.
REQ-002 Parameter DEPTH, default 32, meaning: number of 8-bit storage words, addressed by a 5-bit addr.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  request strobe from the initiator, sampled only in IDLE.
REQ-006 write  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  5  word address; sampled with req.
REQ-008 wdata  input  8  write data; sampled with req.
REQ-009 inj_err  input  1  parity-corruption control; sampled with req; used only under the parity option.
REQ-010 ack  output  1  one-cycle completion pulse.
REQ-011 rdata  output  8  read data; valid while ack=1 for a read.
REQ-012 busy  output  1  high from the cycle after acceptance until the cycle ack is high, inclusive.
REQ-013 parity_err  output  1  read parity-error flag; valid only with ack.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 IDLE with req=1 SHALL latch write, addr, wdata and inj_err, and go to WAIT if WAIT_STATES>0, else to RESP.
REQ-016 WAIT SHALL load a down-counter with WAIT_STATES-1 on entry, decrement it each cycle, and go to RESP when it reaches 0.
REQ-017 RESP SHALL assert ack for exactly one cycle and then return to IDLE unconditionally.
REQ-018 ack SHALL rise exactly WAIT_STATES+1 cycles after the edge that accepted req.
REQ-019 A latched write SHALL commit to storage on the edge entering RESP.
REQ-020 A latched read SHALL load rdata from storage on the edge entering RESP, and rdata SHALL hold that value until the next read.
REQ-021 In WAIT and RESP, req SHALL be ignored; there is no queueing.
REQ-022 req still high in the IDLE cycle after ack SHALL be accepted as a new transaction.
REQ-023 A read following a write to the same address SHALL return the newly written data.
REQ-024 Address DEPTH-1 (31) SHALL be fully usable, with no wrap to 0.
REQ-025 For writes, parity_err SHALL be 0.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, ack=0, busy=0, rdata=8'h00, parity_err=0, wait counter=0, all storage words=8'h00.
REQ-027 Reset asserted in WAIT SHALL abort the transaction, with no storage write committed and no ack.
REQ-028 After rst falls, the first rising edge with req=1 SHALL be accepted normally.

Configuration
REQ-029 Macro MEM_TARGET_PARITY_EN, when defined, SHALL add one even-parity bit per word, stored on write as ^wdata XOR inj_err.
REQ-030 With MEM_TARGET_PARITY_EN defined, a read SHALL recompute parity on the stored word and set parity_err=1 alongside ack on mismatch.
REQ-031 Without MEM_TARGET_PARITY_EN: no parity storage, inj_err ignored, parity_err tied 0; ports unchanged.

Verification
REQ-032 Scenario: WAIT_STATES=1; write addr=5'h03 wdata=8'hA5, then read addr=5'h03 -> each ack exactly 2 cycles after acceptance; read rdata=8'hA5.
REQ-033 Scenario: WAIT_STATES=0; back-to-back writes 8'h11 to addr 0 and 8'h22 to addr 31, then reads of both -> ack 1 cycle after each acceptance; data 8'h11 and 8'h22, no wrap aliasing.
REQ-034 Scenario: WAIT_STATES=3; req held high for 10 cycles during a read -> exactly two acks, at cycles 4 and 9 after the first acceptance; busy low only in the IDLE cycles.
REQ-035 Scenario: write 8'h7E to addr 8, start a write of 8'hFF to addr 8, pulse rst in WAIT, then read addr 8 -> read returns 8'h00 (reset clear, aborted write not committed); no ack before reset.
REQ-036 Scenario (MEM_TARGET_PARITY_EN): write addr 2 with inj_err=1, then read addr 2 -> parity_err=1 with ack; write addr 4 with inj_err=0, then read addr 4 -> parity_err=0.

Source files
------------

// File: rtl/mem_target.sv
// Single-port 32x8 memory target with a req/ack handshake and WAIT_STATES extra latency.
// Optional per-word even parity with error injection is enabled by defining MEM_TARGET_PARITY_EN.
module mem_target #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DEPTH       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       write,
    input  logic [4:0] addr,
    input  logic [7:0] wdata,
    input  logic       inj_err,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       parity_err
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT_STATES != 0) ? CW'(WAIT_STATES - 1) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            write_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   mem [DEPTH];

    logic            accept;
    logic            commit;
    logic            ack_d;
    logic            busy_d;
    logic            op_write;
    logic [AW-1:0]   op_addr;
    logic [DW-1:0]   op_wdata;

`ifdef MEM_TARGET_PARITY_EN
    logic            inj_q;
    logic            op_inj;
    logic            par [DEPTH];
    logic            perr_d;
`else
    logic            unused_inj;
    assign unused_inj = inj_err;
    assign parity_err = 1'b0;
`endif

    // Next state, wait counter and handshake outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_STATES != 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ack_d  = (state_q == RESP);
        busy_d = (state_d != IDLE) || (state_q == RESP);
    end

    // With zero wait states the commit happens on the accepting edge, before the latch is loaded.
    always_comb begin
        op_write = write_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state_q == IDLE) begin
            op_write = write;
            op_addr  = addr;
            op_wdata = wdata;
        end
    end

`ifdef MEM_TARGET_PARITY_EN
    always_comb begin
        op_inj = (state_q == IDLE) ? inj_err : inj_q;
        perr_d = (state_q == RESP) && !write_q && ((^rdata) != par[addr_q]);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
            mem     <= '{default: '0};
`ifdef MEM_TARGET_PARITY_EN
            inj_q      <= 1'b0;
            par        <= '{default: 1'b0};
            parity_err <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack     <= ack_d;
            busy    <= busy_d;
            if (accept) begin
                write_q <= write;
                addr_q  <= addr;
                wdata_q <= wdata;
`ifdef MEM_TARGET_PARITY_EN
                inj_q   <= inj_err;
`endif
            end
            if (commit) begin
                if (op_write) begin
                    mem[op_addr] <= op_wdata;
`ifdef MEM_TARGET_PARITY_EN
                    par[op_addr] <= (^op_wdata) ^ op_inj;
`endif
                end else begin
                    rdata <= mem[op_addr];
                end
            end
`ifdef MEM_TARGET_PARITY_EN
            parity_err <= perr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_target.sv
// Bench for mem_target: three instances (WAIT_STATES 0, 1, 3) share stimulus and are each
// checked every cycle against an edge-scheduled transaction model, plus literal scenario checks.
`timescale 1ns/1ps
module tb_mem_target;

`ifdef MEM_TARGET_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       write;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       inj_err;
    logic [2:0] ack_w;
    logic [2:0] busy_w;
    logic [2:0] perr_w;
    logic [7:0] rdata_w [3];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%0h exp=%0h at %0t", name, g, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        mem_target #(.WAIT_STATES(WS), .DEPTH(32)) dut (
            .clk(clk), .rst(rst), .req(req), .write(write), .addr(addr),
            .wdata(wdata), .inj_err(inj_err), .ack(ack_w[g]), .rdata(rdata_w[g]),
            .busy(busy_w[g]), .parity_err(perr_w[g])
        );

        // Transaction model: accept at edge a, storage op at a+WS, ack visible after a+WS+1.
        int         e, last_a, ack_e, op_e;
        bit         pend, p_w, p_inj, ack_pe;
        logic [4:0] p_a;
        logic [7:0] p_d;
        logic [7:0] m_mem [32];
        bit         m_bad [32];
        logic [7:0] m_rdata;
        bit         m_ack, m_busy, m_perr;

        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[i] = 8'h00;
                    m_bad[i] = 1'b0;
                end
                e = 0; last_a = -100; ack_e = -100; op_e = -100;
                pend = 1'b0; ack_pe = 1'b0;
                m_rdata = 8'h00; m_ack = 1'b0; m_busy = 1'b0; m_perr = 1'b0;
            end else begin
                e++;
                m_ack  = (e == ack_e);
                m_perr = m_ack && ack_pe;
                if (req && (e >= last_a + WS + 2)) begin
                    last_a = e; ack_e = e + WS + 1; op_e = e + WS; pend = 1'b1;
                    p_w = write; p_a = addr; p_d = wdata; p_inj = inj_err;
                end
                if (pend && e == op_e) begin
                    pend = 1'b0;
                    if (p_w) begin
                        m_mem[p_a] = p_d;
                        m_bad[p_a] = PAR_ON && p_inj;
                        ack_pe = 1'b0;
                    end else begin
                        m_rdata = m_mem[p_a];
                        ack_pe  = m_bad[p_a];
                    end
                end
                m_busy = (e >= last_a) && (e <= last_a + WS + 1);
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                if (rst) begin
                    chk("rst_ack", g, 32'(ack_w[g]), 0);
                    chk("rst_busy", g, 32'(busy_w[g]), 0);
                    chk("rst_rdata", g, 32'(rdata_w[g]), 0);
                    chk("rst_perr", g, 32'(perr_w[g]), 0);
                end else begin
                    chk("ack", g, 32'(ack_w[g]), 32'(m_ack));
                    chk("busy", g, 32'(busy_w[g]), 32'(m_busy));
                    chk("rdata", g, 32'(rdata_w[g]), 32'(m_rdata));
                    chk("perr", g, 32'(perr_w[g]), 32'(m_perr));
                end
            end
        end
    end

    int         lat [3];
    logic [7:0] rd  [3];
    logic       pe  [3];

    // One isolated transaction; records latency, read data and parity flag per instance.
    task automatic do_txn(input bit w, input logic [4:0] a, input logic [7:0] d, input bit inj);
        @(posedge clk); #1;
        req = 1'b1; write = w; addr = a; wdata = d; inj_err = inj;
        @(posedge clk); #1;
        req = 1'b0; write = 1'($urandom); addr = 5'($urandom); wdata = 8'($urandom); inj_err = 1'($urandom);
        for (int g = 0; g < 3; g++) begin
            lat[g] = 0; rd[g] = 8'hxx; pe[g] = 1'bx;
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (ack_w[g] && lat[g] == 0) begin
                    lat[g] = k; rd[g] = rdata_w[g]; pe[g] = perr_w[g];
                end
            end
        end
        for (int g = 0; g < 3; g++) chk("latency", g, lat[g], ws_of(g) + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] amask [3];
        logic [15:0] bmask [3];
        rst = 1'b1; req = 1'b0; write = 1'b0; addr = '0; wdata = '0; inj_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("reset_ack", g, 32'(ack_w[g]), 0);
            chk("reset_busy", g, 32'(busy_w[g]), 0);
            chk("reset_rdata", g, 32'(rdata_w[g]), 0);
        end

        // Write then read back the same address.
        do_txn(1'b1, 5'h03, 8'hA5, 1'b0);
        do_txn(1'b0, 5'h03, 8'h00, 1'b0);
        for (int g = 0; g < 3; g++) begin
            chk("rd_a5", g, 32'(rd[g]), 32'h A5);
            chk("rd_a5_perr", g, 32'(pe[g]), 0);
        end

        // Lowest and highest addresses do not alias.
        do_txn(1'b1, 5'd0, 8'h11, 1'b0);
        do_txn(1'b1, 5'd31, 8'h22, 1'b0);
        do_txn(1'b0, 5'd0, 8'h00, 1'b0);
        for (int g = 0; g < 3; g++) chk("rd_addr0", g, 32'(rd[g]), 32'h11);
        do_txn(1'b0, 5'd31, 8'h00, 1'b0);
        for (int g = 0; g < 3; g++) chk("rd_addr31", g, 32'(rd[g]), 32'h22);

        // req held high for ten sampled edges during a read.
        @(posedge clk); #1;
        req = 1'b1; write = 1'b0; addr = 5'h03;
        @(posedge clk);
        for (int g = 0; g < 3; g++) begin
            amask[g] = '0; bmask[g] = '0;
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 9) req = 1'b0;
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                amask[g][k] = ack_w[g];
                bmask[g][k] = busy_w[g];
            end
        end
        chk("hold_acks", 0, 32'(amask[0]), 32'h02AA);
        chk("hold_acks", 1, 32'(amask[1]), 32'h0924);
        chk("hold_acks", 2, 32'(amask[2]), 32'h0210);
        chk("hold_busy", 0, 32'(bmask[0]), 32'h03FE);
        chk("hold_busy", 1, 32'(bmask[1]), 32'h0FFE);
        chk("hold_busy", 2, 32'(bmask[2]), 32'h03FE);

        // Reset during an in-flight write clears storage and suppresses the ack.
        do_txn(1'b1, 5'd8, 8'h7E, 1'b0);
        @(posedge clk); #1;
        req = 1'b1; write = 1'b1; addr = 5'd8; wdata = 8'hFF;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) chk("abort_ack", g, 32'(ack_w[g]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_txn(1'b0, 5'd8, 8'h00, 1'b0);
        for (int g = 0; g < 3; g++) chk("rd_after_abort", g, 32'(rd[g]), 32'h00);

        // Parity injection.
        do_txn(1'b1, 5'd2, 8'h5A, 1'b1);
        do_txn(1'b0, 5'd2, 8'h00, 1'b0);
        for (int g = 0; g < 3; g++) chk("perr_inj", g, 32'(pe[g]), 32'(PAR_ON));
        do_txn(1'b1, 5'd4, 8'h3C, 1'b0);
        do_txn(1'b0, 5'd4, 8'h00, 1'b1);
        for (int g = 0; g < 3; g++) begin
            chk("perr_clean", g, 32'(pe[g]), 0);
            chk("rd_addr4", g, 32'(rd[g]), 32'h3C);
        end

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 79) == 0) rst = 1'b1;
            req     = ($urandom_range(0, 2) != 0);
            write   = 1'($urandom);
            wdata   = 8'($urandom);
            inj_err = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       addr = 5'd0;
                1:       addr = 5'd31;
                2:       addr = 5'($urandom);
                default: addr = 5'($urandom_range(0, 3));
            endcase
        end
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
